// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, the fetch stage, the loader and the RAM.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface imem_port_arbiter_if #(
    parameter int unsigned AW = 7
);
    logic          f_req;
    logic [31:0]   f_adr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [31:0]   f_rdata;

    logic          l_req;
    logic          l_we;
    logic [31:0]   l_adr;
    logic [31:0]   l_wdata;
    logic          l_lock;
    logic          l_gnt;
    logic          l_rvalid;
    logic [31:0]   l_rdata;
    logic          l_err;
    logic [15:0]   l_wcnt;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_adr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;

    logic          core_stall;

    modport slave (
        input  f_req, f_adr,
        output f_gnt, f_rvalid, f_rdata,
        input  l_req, l_we, l_adr, l_wdata, l_lock,
        output l_gnt, l_rvalid, l_rdata, l_err, l_wcnt,
        output m_en, m_we, m_adr, m_wdata,
        input  m_rdata,
        output core_stall
    );

    modport master (
        output f_req, f_adr,
        input  f_gnt, f_rvalid, f_rdata,
        output l_req, l_we, l_adr, l_wdata, l_lock,
        input  l_gnt, l_rvalid, l_rdata, l_err, l_wcnt,
        input  m_en, m_we, m_adr, m_wdata,
        output m_rdata,
        input  core_stall
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares a single-port synchronous instruction RAM between the fetch port and the loader,
// with round-robin arbitration and an exclusive loader lock session.
module imem_port_arbiter #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    imem_port_arbiter_if.slave bus
);
    typedef enum logic { RUN, LOCKED } state_t;
    typedef enum logic { PREF_FETCH, PREF_LOAD } pref_t;

    state_t        state_q, state_d;
    pref_t         pref_q, pref_d;

    logic          f_oor, l_oor;
    logic          f_gnt, l_gnt;
    logic          m_en, m_we;
    logic [AW-1:0] m_adr;

    logic          f_rv_q, l_rv_q, oor_q, lwr_q;
    logic [15:0]   wcnt_q, wcnt_d;
    logic          l_commit;

    logic          unused_adr_bits;
    assign unused_adr_bits = ^{bus.f_adr[1:0], bus.l_adr[1:0]};

    // Range check covers the full word address, not just the AW bits driven to the RAM.
    assign f_oor = (bus.f_adr[31:2] >= 30'(DEPTH));
    assign l_oor = (bus.l_adr[31:2] >= 30'(DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            pref_q  <= PREF_FETCH;
        end else begin
            state_q <= state_d;
            pref_q  <= pref_d;
        end
    end

    always_comb begin
        state_d = bus.l_lock ? LOCKED : RUN;
        f_gnt   = 1'b0;
        l_gnt   = 1'b0;
        pref_d  = pref_q;

        if (state_q == LOCKED) begin
            l_gnt = bus.l_req;
        end else if (bus.f_req && bus.l_req) begin
            if (pref_q == PREF_FETCH) begin
                f_gnt = 1'b1;
            end else begin
                l_gnt = 1'b1;
            end
        end else begin
            f_gnt = bus.f_req;
            l_gnt = bus.l_req;
        end

        if (f_gnt) begin
            pref_d = PREF_LOAD;
        end else if (l_gnt) begin
            pref_d = PREF_FETCH;
        end

        // Leaving a lock session always hands the first contended slot back to fetch.
        if (state_q == LOCKED && state_d == RUN) begin
            pref_d = PREF_FETCH;
        end
    end

    always_comb begin
        m_en  = 1'b0;
        m_we  = 1'b0;
        m_adr = '0;
        if (f_gnt) begin
            m_en  = ~f_oor;
            m_adr = bus.f_adr[AW+1:2];
        end else if (l_gnt) begin
            m_en  = ~l_oor;
            m_we  = bus.l_we & ~l_oor;
            m_adr = bus.l_adr[AW+1:2];
        end
    end

    assign l_commit = (state_q == LOCKED) && l_gnt && bus.l_we && !l_oor;

    always_comb begin
        wcnt_d = wcnt_q;
        if (state_q == RUN && state_d == LOCKED) begin
            wcnt_d = '0;
        end else if (l_commit && wcnt_q != 16'hFFFF) begin
            wcnt_d = wcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_rv_q <= 1'b0;
            l_rv_q <= 1'b0;
            oor_q  <= 1'b0;
            lwr_q  <= 1'b0;
            wcnt_q <= '0;
        end else begin
            f_rv_q <= f_gnt;
            l_rv_q <= l_gnt;
            oor_q  <= f_gnt ? f_oor : (l_gnt & l_oor);
            lwr_q  <= l_gnt & bus.l_we;
            wcnt_q <= wcnt_d;
        end
    end

    assign bus.f_gnt      = f_gnt;
    assign bus.l_gnt      = l_gnt;
    assign bus.m_en       = m_en;
    assign bus.m_we       = m_we;
    assign bus.m_adr      = m_adr;
    assign bus.m_wdata    = bus.l_wdata;
    assign bus.core_stall = (bus.f_req & ~f_gnt) | (state_q == LOCKED);

    assign bus.f_rvalid   = f_rv_q;
    assign bus.f_rdata    = (f_rv_q && !oor_q) ? bus.m_rdata : '0;
    assign bus.l_rvalid   = l_rv_q;
    assign bus.l_rdata    = (l_rv_q && !oor_q && !lwr_q) ? bus.m_rdata : '0;
    assign bus.l_err      = l_rv_q & oor_q;
    assign bus.l_wcnt     = wcnt_q;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the arbiter and its RAM.
module tb_imem_port_arbiter;
    localparam int unsigned DEPTH = 128;
    localparam int unsigned AW    = 7;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_port_arbiter_if #(.AW(AW)) bus ();

    imem_port_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned i);
        case (i)
            0:       return 32'h06400513;
            1:       return 32'h00A00593;
            2:       return 32'h00B52023;
            default: return i * 32'h9E3779B9;
        endcase
    endfunction

    // Synchronous-read RAM sitting on the memory side of the arbiter
    logic [31:0] ram [DEPTH];
    logic        load_now = 1'b0;
    always @(posedge clk) begin
        if (load_now) begin
            for (int i = 0; i < int'(DEPTH); i++) ram[i] <= init_word(i);
        end else if (bus.m_en) begin
            if (bus.m_we) ram[bus.m_adr] <= bus.m_wdata;
            else          bus.m_rdata    <= ram[bus.m_adr];
        end
    end

    // Reference model: arbitration state plus the expected response for the current cycle
    logic [31:0] ref_mem [DEPTH];
    bit          model_init = 1'b0;
    bit          chk_en     = 1'b0;
    bit          m_locked   = 1'b0;
    bit          m_pref_f   = 1'b1;
    logic [15:0] m_wcnt     = '0;
    bit          xf_v = 1'b0, xl_v = 1'b0, xl_e = 1'b0;
    logic [31:0] xf_d = '0, xl_d = '0;

    bit          c_gf, c_gl, c_foor, c_loor, c_en;
    logic [31:0] c_fw, c_lw;

    always @(negedge clk) begin
        if (!model_init) begin
            for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);
            model_init = 1'b1;
        end
        if (chk_en) begin
            chk1("f_rvalid", bus.f_rvalid, xf_v);
            chk ("f_rdata",  bus.f_rdata,  xf_d);
            chk1("l_rvalid", bus.l_rvalid, xl_v);
            chk ("l_rdata",  bus.l_rdata,  xl_d);
            chk1("l_err",    bus.l_err,    xl_e);
            chk ("l_wcnt",   32'(bus.l_wcnt), 32'(m_wcnt));

            c_fw   = bus.f_adr >> 2;
            c_lw   = bus.l_adr >> 2;
            c_foor = c_fw >= DEPTH;
            c_loor = c_lw >= DEPTH;
            if (m_locked) begin
                c_gf = 1'b0;
                c_gl = bus.l_req;
            end else if (bus.f_req && bus.l_req) begin
                c_gf = m_pref_f;
                c_gl = !m_pref_f;
            end else begin
                c_gf = bus.f_req;
                c_gl = bus.l_req;
            end
            c_en = (c_gf && !c_foor) || (c_gl && !c_loor);

            if (rst_n) begin
                chk1("f_gnt",      bus.f_gnt,      c_gf);
                chk1("l_gnt",      bus.l_gnt,      c_gl);
                chk1("core_stall", bus.core_stall, (bus.f_req && !c_gf) || m_locked);
                chk1("m_en",       bus.m_en,       c_en);
                if (c_en) begin
                    chk ("m_adr", 32'(bus.m_adr), c_gf ? c_fw[AW-1:0] : c_lw[AW-1:0]);
                    chk1("m_we",  bus.m_we,       c_gl && bus.l_we);
                    if (c_gl && bus.l_we) chk("m_wdata", bus.m_wdata, bus.l_wdata);
                end else if (!c_gf && !c_gl) begin
                    chk1("m_we_idle", bus.m_we, 1'b0);
                end
            end

            if (!rst_n) begin
                m_locked = 1'b0;
                m_pref_f = 1'b1;
                m_wcnt   = '0;
                xf_v = 1'b0; xl_v = 1'b0; xl_e = 1'b0; xf_d = '0; xl_d = '0;
            end else begin
                xf_v = c_gf;
                xf_d = (c_gf && !c_foor) ? ref_mem[c_fw[AW-1:0]] : '0;
                xl_v = c_gl;
                xl_e = c_gl && c_loor;
                xl_d = (c_gl && !c_loor && !bus.l_we) ? ref_mem[c_lw[AW-1:0]] : '0;
                if (c_gl && bus.l_we && !c_loor) ref_mem[c_lw[AW-1:0]] = bus.l_wdata;
                if (!m_locked && bus.l_lock) m_wcnt = '0;
                else if (m_locked && c_gl && bus.l_we && !c_loor && m_wcnt != 16'hFFFF)
                    m_wcnt = m_wcnt + 16'd1;
                if (c_gf) m_pref_f = 1'b0;
                else if (c_gl) m_pref_f = 1'b1;
                if (m_locked && !bus.l_lock) m_pref_f = 1'b1;
                m_locked = bus.l_lock;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic fr, input logic [31:0] fa, input logic lr, input logic lw,
                         input logic [31:0] la, input logic [31:0] ld, input logic lk);
        bus.f_req   = fr;
        bus.f_adr   = fa;
        bus.l_req   = lr;
        bus.l_we    = lw;
        bus.l_adr   = la;
        bus.l_wdata = ld;
        bus.l_lock  = lk;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    function automatic logic [31:0] rand_adr();
        if ($urandom_range(0, 15) == 0) return $urandom;
        return ($urandom_range(0, DEPTH + 11) << 2) | $urandom_range(0, 3);
    endfunction

    initial begin
        logic lk;
        rst_n    = 1'b0;
        load_now = 1'b1;
        idle();
        step();
        load_now = 1'b0;
        chk_en   = 1'b1;
        step();
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk1("rst_f_rvalid", bus.f_rvalid, 1'b0);
        chk1("rst_l_rvalid", bus.l_rvalid, 1'b0);
        chk1("rst_l_err",    bus.l_err,    1'b0);
        chk ("rst_l_wcnt",   32'(bus.l_wcnt), 32'd0);
        chk1("rst_stall",    bus.core_stall, 1'b0);
        step();

        // Fetch only
        drive(1'b1, 32'h0, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk); chk1("fo_gnt0", bus.f_gnt, 1'b1); chk1("fo_stall", bus.core_stall, 1'b0);
        step();
        drive(1'b1, 32'h4, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk); chk1("fo_rv0", bus.f_rvalid, 1'b1); chk("fo_d0", bus.f_rdata, 32'h06400513);
        step();
        drive(1'b1, 32'h8, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk); chk("fo_d1", bus.f_rdata, 32'h00A00593);
        step();
        idle();
        @(negedge clk); chk("fo_d2", bus.f_rdata, 32'h00B52023);
        step();

        // Lock session
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        step();
        drive(1'b1, 32'h1C, 1'b1, 1'b1, 32'h1C, 32'h00000293, 1'b1);
        @(negedge clk);
        chk1("lk_fgnt", bus.f_gnt, 1'b0); chk1("lk_lgnt", bus.l_gnt, 1'b1);
        chk1("lk_stall", bus.core_stall, 1'b1); chk("lk_madr", 32'(bus.m_adr), 32'd7);
        step();
        drive(1'b1, 32'h1C, 1'b1, 1'b1, 32'h20, 32'h00300313, 1'b1);
        @(negedge clk); chk1("lk_stall2", bus.core_stall, 1'b1); chk1("lk_wr_rv", bus.l_rvalid, 1'b1);
        step();
        drive(1'b1, 32'h1C, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk); chk1("lk_stall3", bus.core_stall, 1'b1); chk("lk_wcnt", 32'(bus.l_wcnt), 32'd2);
        step();
        drive(1'b1, 32'h1C, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk); chk1("ul_fgnt", bus.f_gnt, 1'b1); chk1("ul_stall", bus.core_stall, 1'b0);
        step();
        idle();
        @(negedge clk); chk("ul_fetch", bus.f_rdata, 32'h00000293); chk("ul_wcnt", 32'(bus.l_wcnt), 32'd2);
        step();

        // Out of range loader read
        drive(1'b0, '0, 1'b1, 1'b0, 32'h200, '0, 1'b0);
        @(negedge clk); chk1("oor_gnt", bus.l_gnt, 1'b1); chk1("oor_men", bus.m_en, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk1("oor_rv", bus.l_rvalid, 1'b1); chk1("oor_err", bus.l_err, 1'b1);
        chk("oor_rdata", bus.l_rdata, 32'h0);
        step();

        // Reset arriving on the edge that would register a fetch response
        rst_n = 1'b0;
        drive(1'b1, 32'h0, 1'b0, 1'b0, '0, '0, 1'b0);
        step();
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        chk1("rma_rv", bus.f_rvalid, 1'b0); chk("rma_wcnt", 32'(bus.l_wcnt), 32'd0);
        chk1("rma_stall", bus.core_stall, 1'b0);
        step();

        // Contention straight after reset
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, '0, 1'b0);
            @(negedge clk);
            chk1("ct_fgnt", bus.f_gnt, (c % 2) == 0);
            chk1("ct_lgnt", bus.l_gnt, (c % 2) == 1);
            chk1("ct_stall", bus.core_stall, (c % 2) == 1);
            step();
        end

        // Lock raised in the same cycle as a granted fetch
        drive(1'b1, 32'h4, 1'b0, 1'b0, '0, '0, 1'b1);
        @(negedge clk); chk1("le_fgnt", bus.f_gnt, 1'b1);
        step();
        drive(1'b1, 32'h4, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        chk1("le_rv", bus.f_rvalid, 1'b1); chk("le_d", bus.f_rdata, 32'h00A00593);
        chk1("le_fgnt0", bus.f_gnt, 1'b0); chk1("le_stall", bus.core_stall, 1'b1);
        step();
        drive(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, '0, 1'b0);
        @(negedge clk); chk1("uf_fgnt", bus.f_gnt, 1'b1); chk1("uf_lgnt", bus.l_gnt, 1'b0);
        step();
        drive(1'b1, 32'h4, 1'b1, 1'b1, 32'h28, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        chk1("wp_lgnt", bus.l_gnt, 1'b1); chk1("wp_fgnt", bus.f_gnt, 1'b0);
        chk1("wp_mwe", bus.m_we, 1'b1); chk1("wp_stall", bus.core_stall, 1'b1);
        step();
        idle();
        @(negedge clk); chk1("wp_rv", bus.l_rvalid, 1'b1); chk("wp_rdata", bus.l_rdata, 32'h0);
        step();

        // Random traffic against the model
        lk = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            rst_n = $urandom_range(0, 299) != 0;
            if (!rst_n) begin
                lk = 1'b0;
                idle();
            end else begin
                if ($urandom_range(0, 19) == 0) lk = ~lk;
                drive($urandom_range(0, 3) != 0, rand_adr(), $urandom_range(0, 1) != 0,
                      $urandom_range(0, 1) != 0, rand_adr(), $urandom, lk);
            end
            step();
        end
        rst_n = 1'b1;
        idle();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
